ca_cell_engine: RTL and testbench

- Datapath responder to the game FSM's command strobes: loadData, readData, writeData, writeout.
- Holds a circular 1-D cellular-automaton row and computes one generation per 16 read/write pairs.
- Commits each generation on writeout and returns loseSig to the FSM.
- Sits beside the FSM on a single clock; the FSM issues commands and this block executes them.

---
 rtl/ca_cell_engine.sv | 125 ++++++++++++
 tb/tb_ca_cell_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ca_cell_engine.sv
// Circular 1-D cellular-automaton row engine driven by the game FSM's command strobes.
// Live row is read during a sweep; next generation builds in shadow and commits on writeout.
module ca_cell_engine #(
    parameter int             CELLS = 16,
    parameter int             IDX_W = 4,
    parameter logic [7:0]     RULE  = 8'h5A,
    parameter int             GEN_W = 9
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              loadData,
    input  logic              readData,
    input  logic              writeData,
    input  logic              writeout,
    input  logic [CELLS-1:0]  data_in,
    output logic [CELLS-1:0]  cell_out,
    output logic              loseSig,
    output logic [GEN_W-1:0]  gen_count,
    output logic [IDX_W-1:0]  cell_idx,
    output logic              seq_err
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELLS - 1);

    logic [CELLS-1:0] live_q,   live_d;
    logic [CELLS-1:0] shadow_q, shadow_d;
    logic [2:0]       nbr_q,    nbr_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [GEN_W-1:0] gen_q,    gen_d;
    logic             lose_q,   lose_d;
    logic             err_q,    err_d;
    logic [1:0]       state_q,  state_d;

    logic [IDX_W-1:0] idx_up;
    logic [IDX_W-1:0] idx_dn;

    // Neighbour pointers wrap around the ring regardless of whether CELLS is a power of two
    assign idx_up = (idx_q == IDX_LAST)    ? '0       : idx_q + 1'b1;
    assign idx_dn = (idx_q == '0)          ? IDX_LAST : idx_q - 1'b1;

    always_comb begin
        live_d   = live_q;
        shadow_d = shadow_q;
        nbr_d    = nbr_q;
        idx_d    = idx_q;
        gen_d    = gen_q;
        lose_d   = lose_q;
        err_d    = err_q;
        state_d  = state_q;

        if (loadData) begin
            live_d   = data_in;
            shadow_d = data_in;
            idx_d    = '0;
            gen_d    = '0;
            lose_d   = 1'b0;
            state_d  = ST_READY;
        end else if (writeout) begin
            if (state_q == ST_READY) begin
                live_d = shadow_q;
                lose_d = (shadow_q == '0);
                if (gen_q != '1) begin
                    gen_d = gen_q + 1'b1;
                end
                if (idx_q != '0) begin
                    err_d = 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end else if (writeData) begin
            if (state_q == ST_HOLD) begin
                shadow_d[idx_q] = RULE[nbr_q];
                idx_d           = idx_up;
                state_d         = ST_READY;
            end else begin
                err_d = 1'b1;
            end
        end else if (readData) begin
            if (state_q == ST_EMPTY) begin
                err_d = 1'b1;
            end else begin
                // A second read before the write is flagged but still refreshes the neighbourhood
                if (state_q == ST_HOLD) begin
                    err_d = 1'b1;
                end
                nbr_d   = {live_q[idx_up], live_q[idx_q], live_q[idx_dn]};
                state_d = ST_HOLD;
            end
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            live_q   <= '0;
            shadow_q <= '0;
            nbr_q    <= '0;
            idx_q    <= '0;
            gen_q    <= '0;
            lose_q   <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= ST_EMPTY;
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
            nbr_q    <= nbr_d;
            idx_q    <= idx_d;
            gen_q    <= gen_d;
            lose_q   <= lose_d;
            err_q    <= err_d;
            state_q  <= state_d;
        end
    end

    assign cell_out  = live_q;
    assign loseSig   = lose_q;
    assign gen_count = gen_q;
    assign cell_idx  = idx_q;
    assign seq_err   = err_q;

endmodule

// File: tb/tb_ca_cell_engine.sv
// Self-checking bench for ca_cell_engine: directed scenarios plus random command streams
// compared against a command-level behavioural model of the cell row.
module tb_ca_cell_engine;

    localparam int CELLS = 16;

    logic              clka = 1'b0;
    logic              rst;
    logic              loadData, readData, writeData, writeout;
    logic [CELLS-1:0]  data_in;
    logic [CELLS-1:0]  cell_out;
    logic              loseSig;
    logic [8:0]        gen_count;
    logic [3:0]        cell_idx;
    logic              seq_err;

    ca_cell_engine dut (
        .clka      (clka),
        .rst       (rst),
        .loadData  (loadData),
        .readData  (readData),
        .writeData (writeData),
        .writeout  (writeout),
        .data_in   (data_in),
        .cell_out  (cell_out),
        .loseSig   (loseSig),
        .gen_count (gen_count),
        .cell_idx  (cell_idx),
        .seq_err   (seq_err)
    );

    always #5 clka = ~clka;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: the row as bit vectors, pointer as an integer, protocol as two flags
    logic [15:0] m_live, m_shadow;
    logic [2:0]  m_nbr;
    int          m_idx, m_gen;
    bit          m_lose, m_err, m_loaded, m_holding;
    logic [7:0]  rule_tbl;

    function automatic bit cell_at(input logic [15:0] row, input int i);
        int k;
        k = ((i % CELLS) + CELLS) % CELLS;
        return row[k];
    endfunction

    function automatic logic [15:0] rule90_gen(input logic [15:0] row);
        logic [15:0] r;
        for (int i = 0; i < CELLS; i++) r[i] = cell_at(row, i - 1) ^ cell_at(row, i + 1);
        return r;
    endfunction

    task automatic model_reset();
        m_live = '0; m_shadow = '0; m_nbr = '0; m_idx = 0; m_gen = 0;
        m_lose = 0; m_err = 0; m_loaded = 0; m_holding = 0;
    endtask

    task automatic model_cmd(input bit ld, input bit rd, input bit wr, input bit wo,
                             input logic [15:0] din);
        if (ld) begin
            m_live = din; m_shadow = din; m_idx = 0; m_gen = 0; m_lose = 0;
            m_loaded = 1; m_holding = 0;
        end else if (wo) begin
            if (m_loaded && !m_holding) begin
                if (m_idx != 0) m_err = 1;
                m_live = m_shadow;
                m_lose = (m_shadow == 0);
                if (m_gen < 511) m_gen++;
            end else m_err = 1;
        end else if (wr) begin
            if (m_holding) begin
                m_shadow[m_idx] = rule_tbl[m_nbr];
                m_idx = (m_idx + 1) % CELLS;
                m_holding = 0;
            end else m_err = 1;
        end else if (rd) begin
            if (!m_loaded) m_err = 1;
            else begin
                if (m_holding) m_err = 1;
                m_nbr = {cell_at(m_live, m_idx + 1), cell_at(m_live, m_idx),
                         cell_at(m_live, m_idx - 1)};
                m_holding = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_cell"}, cell_out, m_live);
        chk({tag, "_lose"}, loseSig, m_lose);
        chk({tag, "_gen"},  gen_count, m_gen);
        chk({tag, "_idx"},  cell_idx, m_idx);
        chk({tag, "_err"},  seq_err, m_err);
    endtask

    task automatic cyc(input string tag, input bit ld, input bit rd, input bit wr,
                       input bit wo, input logic [15:0] din);
        @(negedge clka);
        loadData = ld; readData = rd; writeData = wr; writeout = wo; data_in = din;
        @(posedge clka);
        #1;
        model_cmd(ld, rd, wr, wo, din);
        loadData = 0; readData = 0; writeData = 0; writeout = 0;
        check_all(tag);
    endtask

    task automatic generation(input string tag);
        for (int i = 0; i < CELLS; i++) begin
            cyc({tag, "_rd"}, 0, 1, 0, 0, '0);
            cyc({tag, "_wr"}, 0, 0, 1, 0, '0);
        end
        cyc({tag, "_wo"}, 0, 0, 0, 1, '0);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clka);
        #2 rst = 1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clka);
        rst = 0;
    endtask

    logic [15:0] ref_row;

    initial begin
        rule_tbl = 8'h5A;
        rst = 1; loadData = 0; readData = 0; writeData = 0; writeout = 0; data_in = '0;
        #3;
        model_reset();
        check_all("por");
        @(negedge clka);
        rst = 0;

        cyc("wo_empty", 0, 0, 0, 1, '0);
        chk("wo_empty_flag", seq_err, 1);

        async_reset("rst1");
        cyc("ld_rd", 1, 1, 0, 0, 16'h0100);
        ref_row = rule90_gen(16'h0100);
        generation("g1");
        chk("g1_const", cell_out, 16'h0280);
        chk("g1_ref", cell_out, ref_row);
        chk("g1_gen", gen_count, 1);
        chk("g1_noerr", seq_err, 0);
        generation("g2");
        chk("g2_const", cell_out, 16'h0440);
        chk("g2_gen", gen_count, 2);

        cyc("ld_wrap", 1, 0, 0, 0, 16'h8001);
        generation("wrap");
        chk("wrap_ref", cell_out, rule90_gen(16'h8001));

        cyc("ld_full", 1, 0, 0, 0, 16'hFFFF);
        generation("ext");
        chk("ext_cell", cell_out, 0);
        chk("ext_lose", loseSig, 1);
        cyc("ld_one", 1, 0, 0, 0, 16'h0001);
        chk("reload_lose", loseSig, 0);
        chk("reload_gen", gen_count, 0);

        cyc("wr_norad", 0, 0, 1, 0, '0);
        chk("wr_norad_err", seq_err, 1);
        chk("wr_norad_idx", cell_idx, 0);

        async_reset("rst2");
        cyc("ld_mid", 1, 0, 0, 0, 16'h1234);
        for (int i = 0; i < 7; i++) begin
            cyc("mid_rd", 0, 1, 0, 0, '0);
            cyc("mid_wr", 0, 0, 1, 0, '0);
        end
        cyc("mid_hold", 0, 1, 0, 0, '0);
        chk("mid_idx7", cell_idx, 7);
        async_reset("rst_mid");
        chk("rst_mid_idx", cell_idx, 0);
        chk("rst_mid_cell", cell_out, 0);
        cyc("empty_rd", 0, 1, 0, 0, '0);
        chk("empty_rd_err", seq_err, 1);

        cyc("ld_zero", 1, 0, 0, 0, 16'h0000);
        for (int i = 0; i < 600; i++) cyc("sat", 0, 0, 0, 1, '0);
        chk("sat_gen", gen_count, 511);
        chk("sat_lose", loseSig, 1);

        async_reset("rst3");
        for (int n = 0; n < 3000; n++) begin
            bit ld, rd, wr, wo;
            logic [15:0] din;
            if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
            ld  = ($urandom_range(0, 49) == 0);
            rd  = $urandom_range(0, 1);
            wr  = $urandom_range(0, 1);
            wo  = ($urandom_range(0, 11) == 0);
            din = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            cyc("rnd", ld, rd, wr, wo, din);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
